// File: rtl/darksocv_reg_tracer.sv
// Register-file change tracer: timestamped per-register change events through a FWFT FIFO.
// Optional REGTRACE_MASK_EN adds a MASK input that excludes registers from tracing.
module darksocv_reg_tracer #(
    parameter  int XLEN    = 32,
    parameter  int NREGS   = 32,
    parameter  int DEPTH   = 8,
    parameter  int TSW     = 32,
    parameter  int SKIP_X0 = 1,
    localparam int IDXW    = $clog2(NREGS),
    localparam int PW      = $clog2(DEPTH),
    localparam int LW      = $clog2(DEPTH) + 1
) (
    input  logic                  XCLK,
    input  logic                  XRES,
    input  logic                  EN,
    input  logic [NREGS*XLEN-1:0] REGS_FLAT,
`ifdef REGTRACE_MASK_EN
    input  logic [NREGS-1:0]      MASK,
`endif
    output logic                  EV_VALID,
    input  logic                  EV_READY,
    output logic [IDXW-1:0]       EV_IDX,
    output logic [XLEN-1:0]       EV_DATA,
    output logic [TSW-1:0]        EV_TIME,
    output logic [LW-1:0]         EV_LEVEL,
    output logic                  PENDING,
    output logic                  STALL
);

    logic [XLEN-1:0] shadow [NREGS];
    logic [XLEN-1:0] cur    [NREGS];
    logic [NREGS-1:0] care;

    logic [IDXW-1:0] m_idx  [DEPTH];
    logic [XLEN-1:0] m_data [DEPTH];
    logic [TSW-1:0]  m_time [DEPTH];

    logic [PW-1:0]   wr_ptr, rd_ptr, rd_nxt;
    logic [LW-1:0]   level, lvl_nxt;
    logic [TSW-1:0]  tstamp;

    logic            hit;
    logic [IDXW-1:0] hit_idx;
    logic [XLEN-1:0] hit_data;
    logic            full, pop, push, drain_empty;

    always_comb begin
        for (int r = 0; r < NREGS; r++)
            cur[r] = REGS_FLAT[r*XLEN +: XLEN];
    end

    always_comb begin
`ifdef REGTRACE_MASK_EN
        care = MASK;
`else
        care = '1;
`endif
        if (SKIP_X0 != 0)
            care[0] = 1'b0;
    end

    // Descending scan so the lowest mismatching index wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int r = NREGS - 1; r >= 0; r--) begin
            if (care[r] && cur[r] != shadow[r]) begin
                hit     = 1'b1;
                hit_idx = IDXW'(r);
            end
        end
    end

    assign hit_data    = cur[hit_idx];
    assign EV_VALID    = level != '0;
    assign EV_LEVEL    = level;
    assign full        = level == LW'(DEPTH);
    assign pop         = EV_VALID & EV_READY;
    assign push        = EN & hit & (~full | pop);
    assign rd_nxt      = rd_ptr + PW'(pop);
    assign lvl_nxt     = level + LW'(push) - LW'(pop);
    assign drain_empty = (level - LW'(pop)) == '0;

    always_ff @(posedge XCLK) begin
        if (push) begin
            m_idx[wr_ptr]  <= hit_idx;
            m_data[wr_ptr] <= hit_data;
            m_time[wr_ptr] <= tstamp;
        end
    end

    always_ff @(posedge XCLK or negedge XRES) begin
        if (!XRES) begin
            for (int r = 0; r < NREGS; r++)
                shadow[r] <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            tstamp  <= '0;
            EV_IDX  <= '0;
            EV_DATA <= '0;
            EV_TIME <= '0;
            PENDING <= 1'b0;
            STALL   <= 1'b0;
        end else begin
            tstamp  <= tstamp + TSW'(1);
            rd_ptr  <= rd_nxt;
            level   <= lvl_nxt;
            PENDING <= hit;
            STALL   <= hit & full & ~pop;
            if (push) begin
                wr_ptr          <= wr_ptr + PW'(1);
                shadow[hit_idx] <= hit_data;
            end
            // Head registers only move while something is queued, so they hold when empty.
            if (lvl_nxt != '0) begin
                if (drain_empty) begin
                    EV_IDX  <= hit_idx;
                    EV_DATA <= hit_data;
                    EV_TIME <= tstamp;
                end else begin
                    EV_IDX  <= m_idx[rd_nxt];
                    EV_DATA <= m_data[rd_nxt];
                    EV_TIME <= m_time[rd_nxt];
                end
            end
        end
    end

endmodule

// File: tb/tb_darksocv_reg_tracer.sv
// Randomised and directed bench for darksocv_reg_tracer against a queue-based event model.
// Mask scenarios run only when REGTRACE_MASK_EN is defined.
module tb_darksocv_reg_tracer;

    localparam int XLEN    = 16;
    localparam int NREGS   = 16;
    localparam int DEPTH   = 8;
    localparam int TSW     = 4;
    localparam int SKIP_X0 = 1;
    localparam int IDXW    = $clog2(NREGS);
    localparam int LW      = $clog2(DEPTH) + 1;

    typedef struct {
        int idx;
        int data;
        int t;
    } ev_t;

    logic                  clk   = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  en    = 1'b0;
    logic                  ready = 1'b0;
    logic [XLEN-1:0]       regs [NREGS];
    logic [NREGS*XLEN-1:0] regs_flat;
    logic [NREGS-1:0]      mask  = '1;

    logic                  ev_valid;
    logic [IDXW-1:0]       ev_idx;
    logic [XLEN-1:0]       ev_data;
    logic [TSW-1:0]        ev_time;
    logic [LW-1:0]         ev_level;
    logic                  pending;
    logic                  stall;

    int   checks   = 0;
    int   failures = 0;
    ev_t  q [$];
    int   shadow [NREGS];
    int   mtime;
    ev_t  h;
    bit   exp_pend;
    bit   exp_stall;

    always #5 clk = ~clk;

    always_comb begin
        for (int r = 0; r < NREGS; r++)
            regs_flat[r*XLEN +: XLEN] = regs[r];
    end

    darksocv_reg_tracer #(
        .XLEN(XLEN), .NREGS(NREGS), .DEPTH(DEPTH),
        .TSW(TSW), .SKIP_X0(SKIP_X0)
    ) dut (
        .XCLK(clk),
        .XRES(rst_n),
        .EN(en),
        .REGS_FLAT(regs_flat),
`ifdef REGTRACE_MASK_EN
        .MASK(mask),
`endif
        .EV_VALID(ev_valid),
        .EV_READY(ready),
        .EV_IDX(ev_idx),
        .EV_DATA(ev_data),
        .EV_TIME(ev_time),
        .EV_LEVEL(ev_level),
        .PENDING(pending),
        .STALL(stall)
    );

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int r = 0; r < NREGS; r++)
            shadow[r] = 0;
        mtime     = 0;
        h         = '{0, 0, 0};
        exp_pend  = 1'b0;
        exp_stall = 1'b0;
    endtask

    task automatic compare_all();
        if (q.size() != 0)
            h = q[0];
        check("valid", 64'(ev_valid), 64'(q.size() != 0));
        check("idx", 64'(ev_idx), 64'(h.idx));
        check("data", 64'(ev_data), 64'(h.data));
        check("time", 64'(ev_time), 64'(h.t));
        check("level", 64'(ev_level), 64'(q.size()));
        check("pending", 64'(pending), 64'(exp_pend));
        check("stall", 64'(stall), 64'(exp_stall));
    endtask

    // One clock: the model applies the tracing rules to the inputs set at the
    // preceding falling edge, then outputs are compared at the next falling edge.
    task automatic step();
        int  hr;
        bit  pop, full, push;
        hr = -1;
        for (int r = (SKIP_X0 != 0 ? 1 : 0); r < NREGS; r++) begin
            if (hr < 0 && mask[r] && int'(regs[r]) != shadow[r])
                hr = r;
        end
        pop       = q.size() != 0 && ready;
        full      = q.size() == DEPTH;
        push      = en && hr >= 0 && (!full || pop);
        exp_pend  = hr >= 0;
        exp_stall = hr >= 0 && full && !pop;
        if (pop)
            void'(q.pop_front());
        if (push) begin
            q.push_back('{hr, int'(regs[hr]), mtime});
            shadow[hr] = int'(regs[hr]);
        end
        mtime = (mtime + 1) % (1 << TSW);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int t0;
        int seen [$];
        for (int r = 0; r < NREGS; r++)
            regs[r] = '0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        rst_n = 1'b1;
        en    = 1'b1;
        ready = 1'b1;
        step();

        // Single change.
        regs[5] = 16'h1234;
        t0 = mtime;
        step();
        check("t2_valid", 64'(ev_valid), 64'd1);
        check("t2_idx", 64'(ev_idx), 64'd5);
        check("t2_data", 64'(ev_data), 64'h1234);
        check("t2_time", 64'(ev_time), 64'(t0));
        step();
        check("t2_pend", 64'(pending), 64'd0);

        // Two changes in one cycle.
        regs[3] = 16'h0033;
        regs[9] = 16'h0099;
        step();
        check("t3_idx_a", 64'(ev_idx), 64'd3);
        t0 = int'(ev_time);
        step();
        check("t3_idx_b", 64'(ev_idx), 64'd9);
        check("t3_dt", 64'(ev_time), 64'((t0 + 1) % (1 << TSW)));
        step();

        // Back-pressure with ten changes.
        ready = 1'b0;
        for (int r = 1; r <= 10; r++)
            regs[r] = 16'(16'h0100 + r);
        repeat (10) step();
        check("t4_level", 64'(ev_level), 64'd8);
        check("t4_stall", 64'(stall), 64'd1);
        ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (ev_valid)
                seen.push_back(int'(ev_idx));
            step();
            if (i == 0)
                check("t4_fullpop", 64'(ev_level), 64'd8);
        end
        check("t4_cnt", 64'(seen.size()), 64'd10);
        for (int i = 0; i < seen.size(); i++)
            check("t4_order", 64'(seen[i]), 64'(i + 1));

        // Register 0 is never traced.
        regs[0] = 16'hffff;
        step();
        check("t5_x0_pend", 64'(pending), 64'd0);
        check("t5_x0_valid", 64'(ev_valid), 64'd0);

`ifdef REGTRACE_MASK_EN
        mask[7] = 1'b0;
        regs[7] = 16'h0777;
        step();
        step();
        check("t6_masked", 64'(ev_valid), 64'd0);
        mask[7] = 1'b1;
        step();
        check("t6_unmask", 64'(ev_idx), 64'd7);
`endif

        // Random traffic, including EN gaps and value collapse.
        for (int i = 0; i < 500; i++) begin
            en    = $urandom_range(0, 9) < 8;
            ready = $urandom_range(0, 9) < 5;
            if ($urandom_range(0, 9) < 4)
                regs[$urandom_range(0, NREGS - 1)] = 16'($urandom_range(0, 3));
            if ($urandom_range(0, 9) < 2)
                regs[$urandom_range(0, NREGS - 1)] = 16'($urandom);
`ifdef REGTRACE_MASK_EN
            if ($urandom_range(0, 9) == 0)
                mask = NREGS'($urandom);
            if ($urandom_range(0, 9) == 0)
                mask = '1;
`endif
            step();
        end

        // Reset mid-run with three events queued.
        mask  = '1;
        en    = 1'b1;
        ready = 1'b1;
        for (int r = 0; r < NREGS; r++)
            regs[r] = 16'(shadow[r]);
        repeat (12) step();
        ready   = 1'b0;
        regs[2] = regs[2] + 16'd1;
        regs[4] = regs[4] + 16'd1;
        regs[6] = regs[6] + 16'd1;
        repeat (3) step();
        check("t1_level_pre", 64'(ev_level), 64'd3);
        #2 rst_n = 1'b0;
        #1;
        check("t1_valid", 64'(ev_valid), 64'd0);
        check("t1_idx", 64'(ev_idx), 64'd0);
        check("t1_data", 64'(ev_data), 64'd0);
        check("t1_time", 64'(ev_time), 64'd0);
        check("t1_level", 64'(ev_level), 64'd0);
        check("t1_pend", 64'(pending), 64'd0);
        check("t1_stall", 64'(stall), 64'd0);
        for (int r = 0; r < NREGS; r++)
            regs[r] = '0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("t1_level_post", 64'(ev_level), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
